// File: rtl/order_issuer.sv
// Host-side order initiator: queues host commands, issues one order at a time to the
// compute engine, snoops its RAM write port for the result and returns it via a response FIFO.
module order_issuer #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int FIFO_DEPTH    = 4,
  parameter int TIMEOUT_SLACK = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_start,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  input  logic [ADDR_WIDTH-1:0] cmd_back,
  output logic                  order_valid,
  output logic [ADDR_WIDTH-1:0] order_start,
  output logic [ADDR_WIDTH-1:0] order_len,
  output logic [ADDR_WIDTH-1:0] order_back,
  input  logic                  order_busy,
  input  logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic                  ram_write_req,
  input  logic [DATA_WIDTH-1:0] ram_write_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_timeout,
  output logic                  err_addr,
  output logic                  err_stray,
  input  logic                  err_clr,
  output logic                  idle
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_WRITE} state_t;

  state_t state;

  logic [ADDR_WIDTH-1:0] cq_start [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] cq_len   [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] cq_back  [FIFO_DEPTH];
  logic [PW-1:0]         cq_wr, cq_rd;
  logic [CW-1:0]         cq_cnt;

  logic [ADDR_WIDTH-1:0] rq_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rq_data [FIFO_DEPTH];
  logic                  rq_to   [FIFO_DEPTH];
  logic [PW-1:0]         rq_wr, rq_rd;
  logic [CW-1:0]         rq_cnt;

  logic [ADDR_WIDTH:0]   wait_cnt;
  logic [ADDR_WIDTH:0]   wait_limit;

  logic                  cmd_push, cmd_pop;
  logic                  rsp_push, rsp_pop;
  logic                  cap, tmo;
  logic [ADDR_WIDTH-1:0] push_addr;
  logic [DATA_WIDTH-1:0] push_data;

  assign cmd_ready = (cq_cnt != CW'(FIFO_DEPTH));
  assign cmd_push  = cmd_valid && cmd_ready;
  // Issue only when a response slot is guaranteed, so a capture never meets a full FIFO.
  assign cmd_pop   = (state == IDLE) && (cq_cnt != '0) && (rq_cnt != CW'(FIFO_DEPTH));

  assign rsp_valid   = (rq_cnt != '0);
  assign rsp_pop     = rsp_valid && rsp_ready;
  assign rsp_addr    = rsp_valid ? rq_addr[rq_rd] : '0;
  assign rsp_data    = rsp_valid ? rq_data[rq_rd] : '0;
  assign rsp_timeout = rsp_valid ? rq_to[rq_rd]   : 1'b0;

  assign idle = (state == IDLE) && (cq_cnt == '0);

  // Sum kept one bit wider than the length so a maximal len cannot wrap.
  assign wait_limit = {1'b0, order_len} + (ADDR_WIDTH+1)'(TIMEOUT_SLACK);

  always_comb begin
    cap       = 1'b0;
    tmo       = 1'b0;
    push_addr = '0;
    push_data = '0;
    if (state == WAIT_WRITE) begin
      if (ram_write_req) begin
        cap       = 1'b1;
        push_addr = ram_addr;
        push_data = ram_write_data;
      end else if (wait_cnt == wait_limit) begin
        tmo = 1'b1;
      end
    end
    rsp_push = cap || tmo;
  end

  // Command FIFO storage
  always_ff @(posedge clk) begin
    if (cmd_push) begin
      cq_start[cq_wr] <= cmd_start;
      cq_len[cq_wr]   <= cmd_len;
      cq_back[cq_wr]  <= cmd_back;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cq_wr  <= '0;
      cq_rd  <= '0;
      cq_cnt <= '0;
    end else begin
      if (cmd_push) cq_wr <= cq_wr + 1'b1;
      if (cmd_pop)  cq_rd <= cq_rd + 1'b1;
      unique case ({cmd_push, cmd_pop})
        2'b10:   cq_cnt <= cq_cnt + 1'b1;
        2'b01:   cq_cnt <= cq_cnt - 1'b1;
        default: cq_cnt <= cq_cnt;
      endcase
    end
  end

  // Response FIFO storage
  always_ff @(posedge clk) begin
    if (rsp_push) begin
      rq_addr[rq_wr] <= push_addr;
      rq_data[rq_wr] <= push_data;
      rq_to[rq_wr]   <= tmo;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rq_wr  <= '0;
      rq_rd  <= '0;
      rq_cnt <= '0;
    end else begin
      if (rsp_push) rq_wr <= rq_wr + 1'b1;
      if (rsp_pop)  rq_rd <= rq_rd + 1'b1;
      unique case ({rsp_push, rsp_pop})
        2'b10:   rq_cnt <= rq_cnt + 1'b1;
        2'b01:   rq_cnt <= rq_cnt - 1'b1;
        default: rq_cnt <= rq_cnt;
      endcase
    end
  end

  // Order FSM; order_len/order_back double as the latched length and back address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      order_valid <= 1'b0;
      order_start <= '0;
      order_len   <= '0;
      order_back  <= '0;
      wait_cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_pop) begin
            order_start <= cq_start[cq_rd];
            order_len   <= cq_len[cq_rd];
            order_back  <= cq_back[cq_rd];
            order_valid <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (order_valid && !order_busy) begin
            order_valid <= 1'b0;
            wait_cnt    <= '0;
            state       <= WAIT_WRITE;
          end
        end
        WAIT_WRITE: begin
          if (rsp_push) state <= IDLE;
          else          wait_cnt <= wait_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_addr  <= 1'b0;
      err_stray <= 1'b0;
    end else begin
      if (cap && (ram_addr != order_back)) err_addr <= 1'b1;
      else if (err_clr)                    err_addr <= 1'b0;
      if (ram_write_req && (state != WAIT_WRITE)) err_stray <= 1'b1;
      else if (err_clr)                           err_stray <= 1'b0;
    end
  end

endmodule
